mem_conv1d_reader: RTL and testbench
====================================

Name: mem_conv1d_reader

Overview:
- Downstream consumer of the 8-entry byte scratch memory: sequences reads through all entries and applies a 3-tap 1-D convolution to the stream.
- Emits one registered result per valid window position; first CNN compute stage after the feature-map scratch memory.
- Drives the memory's rd_en/wr_en/addr and samples its combinational data_out in the same cycle.

Parameters:
- DATA_W, 8, width of memory samples (unsigned).
- ADDR_W, 3, memory address width.
- DEPTH, 8, number of entries read per run (2**ADDR_W; must be >= 3).
- W_W, 8, kernel weight width (signed two's complement).
- OUT_W, 18, result width (signed); must be >= DATA_W+W_W+2.
- RELU, 0, 1 = clamp negative results to 0 before output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle run request, sampled only in IDLE.
- k0  input  W_W  signed weight for oldest sample x[n-2].
- k1  input  W_W  signed weight for x[n-1].
- k2  input  W_W  signed weight for newest sample x[n].
- mem_rd_en  output  1  read enable to memory.
- mem_wr_en  output  1  write enable to memory; constant 0.
- mem_addr  output  ADDR_W  read address.
- mem_data  input  DATA_W  memory read data, valid in the same cycle as mem_rd_en/mem_addr.
- out_valid  output  1  one-cycle strobe, out_data valid.
- out_data  output  OUT_W  signed convolution result.
- busy  output  1  high from the cycle after start is accepted until DONE completes.
- done  output  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (async, reset=0): state IDLE; mem_rd_en=0, mem_wr_en=0, mem_addr=0, out_valid=0, out_data=0, busy=0, done=0; window and weight registers cleared.
- States: IDLE -> READ -> DONE -> IDLE.
- IDLE: when start=1, latch k0/k1/k2, clear the read counter, and go to READ. busy=1 from the next cycle.
- READ: one cycle per address i = 0..DEPTH-1.
  - mem_rd_en=1 and mem_addr=i are registered outputs, so they are valid throughout the cycle.
  - mem_data is captured at the cycle's rising edge into a 2-deep window (w1 <= w0, w0 <= mem_data).
- Compute: in READ cycles with i >= 2, y = k0*w1 + k1*w0 + k2*mem_data, using zero-extended samples and sign-extended weights at full OUT_W width.
  - y is registered to out_data with out_valid=1 in the following cycle.
  - Results per run: DEPTH-2 (6 by default).
- Timing with start sampled at edge T0:
  - READ addr i occupies cycle T0+1+i.
  - out_valid is high during cycles T0+4 .. T0+9.
  - The last READ (i=7) is cycle T0+8; DONE is cycle T0+9, where the last out_valid coincides with done=1.
  - Return to IDLE at T0+10; busy falls to 0 at T0+10.
- out_data holds its last value when out_valid=0. mem_addr returns to 0 and mem_rd_en to 0 in DONE/IDLE.
- RELU=1: negative y is output as 0. out_valid timing is unchanged.
- Overflow: cannot occur at the default widths (range -97920..97155 fits in 18-bit signed). No saturation logic.
- start while busy: ignored, with no queueing. start in the DONE cycle is also ignored; a new run needs start in IDLE.
- Weights change mid-run: no effect; the latched copies are used.
- Reset mid-run: immediate abort to the reset values. No partial done pulse after reset release.
- mem_wr_en is never asserted, so the memory's write path (active only when rd_en=0) cannot collide with reads.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, READ=2'd1, DONE=2'd2);
  - default widths DATA_W/ADDR_W/W_W/OUT_W;
  - the OUT_W legality check constant.
- One sub-module is natural: conv3_mac, a purely combinational 3-tap signed MAC (three products plus adder tree, optional ReLU) instantiated once.
- FSM, counter and window stay in the top module.

Test Plan:
- Memory preloaded 1..8, k=(1,1,1), pulse start -> out_valid at T0+4..T0+9 with out_data 6,9,12,15,18,21; done=1 at T0+9; busy low at T0+10.
- Same data, k=(-1,0,1) -> six outputs all equal 2; with k=(1,0,-1) -> six outputs of -2 (0x3FFFE in 18 bits).
- All entries 255, k=(127,127,127) -> 97155 each; k=(-128,-128,-128) -> -97920 each, with RELU=0.
- RELU=1, data 1..8, k=(0,0,-1) -> six outputs of 0, with out_valid still asserted six times.
- start re-pulsed at T0+3 and at T0+9 -> ignored: exactly 6 results and one done; mem_addr sequence is 0..7 once.
- reset asserted at T0+5 -> all outputs 0 immediately; after release no out_valid/done until a new start; the next run reproduces the first scenario's values.

Source files
------------

// File: rtl/mem_conv1d_reader_pkg.sv
// Shared constants for the conv1d memory reader:
// FSM encoding, default widths and the result-width legality check.
package mem_conv1d_reader_pkg;

  localparam int DATA_W_D = 8;
  localparam int ADDR_W_D = 3;
  localparam int W_W_D    = 8;
  localparam int OUT_W_D  = 18;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Three full-range products need two guard bits above the raw
  // product width to never wrap.
  function automatic bit out_w_ok(input int dw, input int ww,
                                  input int ow);
    return ow >= dw + ww + 2;
  endfunction

  localparam bit OUT_W_D_OK = out_w_ok(DATA_W_D, W_W_D, OUT_W_D);

endpackage

// File: rtl/mem_conv1d_reader_mac.sv
// conv3_mac: combinational 3-tap MAC, unsigned samples x signed weights.
// Ports: i_x0..i_x2 samples (x0 oldest), i_k0..i_k2 weights, o_y result.
module conv3_mac
  import mem_conv1d_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int W_W    = W_W_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int RELU   = 0
) (
  input  logic        [DATA_W-1:0] i_x0,
  input  logic        [DATA_W-1:0] i_x1,
  input  logic        [DATA_W-1:0] i_x2,
  input  logic signed [W_W-1:0]    i_k0,
  input  logic signed [W_W-1:0]    i_k1,
  input  logic signed [W_W-1:0]    i_k2,
  output logic signed [OUT_W-1:0]  o_y
);

  logic signed [OUT_W-1:0] w_x0, w_x1, w_x2;
  logic signed [OUT_W-1:0] w_k0, w_k1, w_k2;
  logic signed [OUT_W-1:0] w_p0, w_p1, w_p2;
  logic signed [OUT_W-1:0] w_sum;

  assign w_x0 = $signed({{(OUT_W-DATA_W){1'b0}}, i_x0});
  assign w_x1 = $signed({{(OUT_W-DATA_W){1'b0}}, i_x1});
  assign w_x2 = $signed({{(OUT_W-DATA_W){1'b0}}, i_x2});

  assign w_k0 = $signed({{(OUT_W-W_W){i_k0[W_W-1]}}, i_k0});
  assign w_k1 = $signed({{(OUT_W-W_W){i_k1[W_W-1]}}, i_k1});
  assign w_k2 = $signed({{(OUT_W-W_W){i_k2[W_W-1]}}, i_k2});

  assign w_p0 = w_x0 * w_k0;
  assign w_p1 = w_x1 * w_k1;
  assign w_p2 = w_x2 * w_k2;

  assign w_sum = w_p0 + w_p1 + w_p2;

  assign o_y = ((RELU != 0) && w_sum[OUT_W-1]) ? '0 : w_sum;

endmodule

// File: rtl/mem_conv1d_reader.sv
// Reads every scratch-memory entry once per run and streams a 3-tap conv.
// Ports: clk/reset(async low), start, k0..k2, mem_* bus, out_*, busy, done.
module mem_conv1d_reader
  import mem_conv1d_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int W_W    = W_W_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int RELU   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W_W-1:0]    k0,
  input  logic [W_W-1:0]    k1,
  input  logic [W_W-1:0]    k2,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  localparam bit OUT_W_OK = out_w_ok(DATA_W, W_W, OUT_W);

  if (!OUT_W_OK || DEPTH < 3) begin : g_bad_cfg
    $error("mem_conv1d_reader: illegal OUT_W or DEPTH");
  end

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(2);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_w0, r_w1;
  logic [W_W-1:0]    r_k0, r_k1, r_k2;
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_busy;
  logic              r_done;

  logic signed [OUT_W-1:0] w_y;

  conv3_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .OUT_W  (OUT_W),
    .RELU   (RELU)
  ) u_mac (
    .i_x0 (r_w1),
    .i_x1 (r_w0),
    .i_x2 (mem_data),
    .i_k0 ($signed(r_k0)),
    .i_k1 ($signed(r_k1)),
    .i_k2 ($signed(r_k2)),
    .o_y  (w_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rd_en     <= 1'b0;
      r_w0        <= '0;
      r_w1        <= '0;
      r_k0        <= '0;
      r_k1        <= '0;
      r_k2        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_k0    <= k0;
            r_k1    <= k1;
            r_k2    <= k2;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
            r_w0    <= '0;
            r_w1    <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          r_w1 <= r_w0;
          r_w0 <= mem_data;
          // The window is full once two older samples are held.
          if (r_addr >= FIRST) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_y;
          end
          if (r_addr == LAST) begin
            r_state <= S_DONE;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = 1'b0;
  assign mem_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_conv1d_reader.sv
// Directed bench for mem_conv1d_reader: two DUTs (RELU=0 and RELU=1)
// reading a shared behavioural 8-entry combinational memory.
module tb_mem_conv1d_reader;

  logic              clk;
  logic              reset;
  logic              start0, start1;
  logic signed [7:0] k0, k1, k2;

  logic              rd0, wr0, ov0, busy0, done0;
  logic [2:0]        addr0;
  logic [17:0]       od0;
  logic [7:0]        md0;
  logic              rd1, wr1, ov1, busy1, done1;
  logic [2:0]        addr1;
  logic [17:0]       od1;
  logic [7:0]        md1;

  logic [7:0] mem [0:7];

  int checks = 0;
  int errors = 0;
  logic sel;

  assign md0 = mem[addr0];
  assign md1 = mem[addr1];

  mem_conv1d_reader #(.RELU(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .k0(k0), .k1(k1), .k2(k2),
    .mem_rd_en(rd0), .mem_wr_en(wr0), .mem_addr(addr0),
    .mem_data(md0), .out_valid(ov0), .out_data(od0),
    .busy(busy0), .done(done0)
  );

  mem_conv1d_reader #(.RELU(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .k0(k0), .k1(k1), .k2(k2),
    .mem_rd_en(rd1), .mem_wr_en(wr1), .mem_addr(addr1),
    .mem_data(md1), .out_valid(ov1), .out_data(od1),
    .busy(busy1), .done(done1)
  );

  logic        s_rd, s_wr, s_ov, s_busy, s_done;
  logic [2:0]  s_addr;
  logic [17:0] s_od;

  assign s_rd   = sel ? rd1   : rd0;
  assign s_wr   = sel ? wr1   : wr0;
  assign s_ov   = sel ? ov1   : ov0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;
  assign s_addr = sel ? addr1 : addr0;
  assign s_od   = sel ? od1   : od0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rd"},   32'(s_rd),   32'd0);
    chk({tag, ".addr"}, 32'(s_addr), 32'd0);
    chk({tag, ".ov"},   32'(s_ov),   32'd0);
    chk({tag, ".busy"}, 32'(s_busy), 32'd0);
    chk({tag, ".done"}, 32'(s_done), 32'd0);
  endtask

  // Full run: expected results are e0, e0+step, ... (six of them).
  // cyc k denotes the clock period T0+k, start sampled at edge T0.
  task automatic run(input string tag, input logic which,
                     input int e0, input int step, input bit repulse);
    logic [17:0] e18;
    int          ev;
    sel = which;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    if (repulse) begin
      k0 = 8'sd77;
      k1 = -8'sd99;
      k2 = 8'sd5;
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      chk($sformatf("%s.c%0d.busy", tag, cyc), 32'(s_busy),
          32'(cyc <= 9));
      chk($sformatf("%s.c%0d.rd", tag, cyc), 32'(s_rd),
          32'(cyc <= 8));
      chk($sformatf("%s.c%0d.addr", tag, cyc), 32'(s_addr),
          (cyc <= 8) ? 32'(cyc - 1) : 32'd0);
      chk($sformatf("%s.c%0d.wr", tag, cyc), 32'(s_wr), 32'd0);
      chk($sformatf("%s.c%0d.ov", tag, cyc), 32'(s_ov),
          32'(cyc >= 4 && cyc <= 9));
      chk($sformatf("%s.c%0d.done", tag, cyc), 32'(s_done),
          32'(cyc == 9));
      if (cyc >= 4) begin
        ev  = (cyc <= 9) ? e0 + step * (cyc - 4) : e0 + step * 5;
        e18 = 18'(ev);
        chk($sformatf("%s.c%0d.data", tag, cyc), 32'(s_od), 32'(e18));
      end
      if (repulse && (cyc == 3 || cyc == 9)) set_start(1'b1);
      tick();
      set_start(1'b0);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  initial begin
    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel    = 1'b0;
    k0 = 8'sd0; k1 = 8'sd0; k2 = 8'sd0;
    load_ramp();
    tick();
    tick();
    chk("rst.d0.data", 32'(od0), 32'd0);
    chk_quiet("rst.d0");
    sel = 1'b1;
    #1;
    chk("rst.d1.data", 32'(od1), 32'd0);
    chk_quiet("rst.d1");
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    k0 = 8'sd1; k1 = 8'sd1; k2 = 8'sd1;
    run("sum", 1'b0, 6, 3, 1'b0);

    k0 = -8'sd1; k1 = 8'sd0; k2 = 8'sd1;
    run("diffp", 1'b0, 2, 0, 1'b0);

    k0 = 8'sd1; k1 = 8'sd0; k2 = -8'sd1;
    run("diffn", 1'b0, -2, 0, 1'b0);

    load_const(8'd255);
    k0 = 8'sd127; k1 = 8'sd127; k2 = 8'sd127;
    run("maxp", 1'b0, 97155, 0, 1'b0);

    k0 = -8'sd128; k1 = -8'sd128; k2 = -8'sd128;
    run("maxn", 1'b0, -97920, 0, 1'b0);

    load_ramp();
    k0 = 8'sd0; k1 = 8'sd0; k2 = -8'sd1;
    run("relu", 1'b1, 0, 0, 1'b0);

    k0 = 8'sd1; k1 = 8'sd1; k2 = 8'sd1;
    run("repulse", 1'b0, 6, 3, 1'b1);

    k0 = 8'sd1; k1 = 8'sd1; k2 = 8'sd1;
    sel = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    reset = 1'b0;
    #1;
    chk("abort.data", 32'(od0), 32'd0);
    chk_quiet("abort");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_quiet($sformatf("post%0d", c));
    end

    run("rerun", 1'b0, 6, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
